// File: rtl/systolic_feeder_pkg.sv
// systolic_feeder_pkg: shared state encoding, default tile geometry and lane slicing helper
package systolic_feeder_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, READY, STREAM} state_t;
  localparam int N_DEF = 4;
  localparam int DW_DEF = 32;
  // Low bit of lane i inside a packed N*DW lane bus: bus[lane_lo(i, DW) +: DW]
  function automatic int lane_lo(input int i, input int dw);
    return i * dw;
  endfunction
endpackage

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: load stream, control and skewed lane outputs of one feeder
//   in_valid/in_ready/in_data : row-major tile load stream
//   start/loaded/busy/done    : stream control and status
//   out_data/out_valid        : N registered edge lanes, lane i at [i*DW +: DW]
interface systolic_feeder_if import systolic_feeder_pkg::*; #(
  parameter int N = N_DEF,
  parameter int DW = DW_DEF
);
  logic in_valid;
  logic in_ready;
  logic [DW-1:0] in_data;
  logic start;
  logic loaded;
  logic busy;
  logic done;
  logic [N*DW-1:0] out_data;
  logic [N-1:0] out_valid;
  modport master (output in_valid, in_data, start, input in_ready, loaded, busy, done, out_data, out_valid);
  modport slave (input in_valid, in_data, start, output in_ready, loaded, busy, done, out_data, out_valid);
endinterface

// File: rtl/systolic_feeder_lane.sv
// systolic_feeder_lane: one edge lane's N-word store; emits word (t - LANE_OFFSET) or zero per step
//   clk         : write clock
//   we/widx/wdata : element write during tile load
//   t           : current skew step
//   word/vld    : combinational lane value for step t, zero when outside the lane window
module systolic_feeder_lane import systolic_feeder_pkg::*; #(
  parameter int N = N_DEF,
  parameter int DW = DW_DEF,
  parameter int LANE_OFFSET = 0,
  localparam int IW = $clog2(N),
  localparam int TW = $clog2(2*N-1)
) (
  input  logic clk,
  input  logic we,
  input  logic [IW-1:0] widx,
  input  logic [DW-1:0] wdata,
  input  logic [TW-1:0] t,
  output logic [DW-1:0] word,
  output logic vld
);
  localparam logic [TW-1:0] FIRST = TW'(LANE_OFFSET);
  localparam logic [TW-1:0] LAST = TW'(LANE_OFFSET + N - 1);
  logic [DW-1:0] mem [N];
  always_ff @(posedge clk)
    if (we) mem[widx] <= wdata;
  assign vld = t >= FIRST && t <= LAST;
  // Zero fill keeps idle slots from adding to the downstream accumulation
  assign word = vld ? mem[IW'(t - FIRST)] : '0;
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one NxN tile and streams it onto N diagonally skewed edge lanes
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : systolic_feeder_if slave (load stream, start/loaded/busy/done, lane outputs)
module systolic_feeder import systolic_feeder_pkg::*; #(
  parameter int N = N_DEF,
  parameter int DW = DW_DEF
) (
  input logic clk,
  input logic rst_n,
  systolic_feeder_if.slave bus
);
  localparam int CW = $clog2(N*N);
  localparam int IW = $clog2(N);
  localparam int TW = $clog2(2*N-1);
  localparam logic [CW-1:0] CLAST = CW'(N*N-1);
  // One step past the last skew step: every lane window is empty, so registering it zeroes the outputs
  localparam logic [TW-1:0] TEND = TW'(2*N-1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] t;
  logic hs;
  logic [N*DW-1:0] nxt_data;
  logic [N-1:0] nxt_valid;
  assign bus.in_ready = state == IDLE || state == LOAD;
  assign hs = bus.in_valid && bus.in_ready;
  for (genvar i = 0; i < N; i++) begin : g_lane
    systolic_feeder_lane #(.N(N), .DW(DW), .LANE_OFFSET(i)) u_lane (
      .clk(clk),
      .we(hs && cnt / CW'(N) == CW'(i)),
      .widx(IW'(cnt % CW'(N))),
      .wdata(bus.in_data),
      .t(t),
      .word(nxt_data[lane_lo(i, DW) +: DW]),
      .vld(nxt_valid[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      t <= '0;
      bus.loaded <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.out_data <= '0;
      bus.out_valid <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, LOAD: if (hs) begin
          cnt <= cnt == CLAST ? '0 : cnt + 1'b1;
          state <= cnt == CLAST ? READY : LOAD;
          bus.loaded <= cnt == CLAST;
        end
        READY: if (bus.start) begin
          state <= STREAM;
          bus.loaded <= 1'b0;
          bus.busy <= 1'b1;
          bus.out_data <= nxt_data;
          bus.out_valid <= nxt_valid;
          t <= t + 1'b1;
        end
        STREAM: begin
          bus.out_data <= nxt_data;
          bus.out_valid <= nxt_valid;
          t <= t == TEND ? '0 : t + 1'b1;
          if (t == TEND) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
      endcase
    end
endmodule
